bht_resolve_updater: RTL and testbench
======================================

Name: bht_resolve_updater

Overview:
- Branch-history table that sits in the frontend and consumes the resolved-branch stream produced by the execute-stage branch unit.
- Trains a direct-mapped array of 2-bit saturating counters from resolved conditional branches.
- Serves taken/not-taken predictions to the fetch PC with one-cycle latency.
- Owns a multi-cycle clear sequencer triggered by flush_bp_i.

Parameters:
- NR_ENTRIES, 64, number of table rows; power of two, >= 4.
- VLEN, 64, virtual-address width of PCs.
- IDX_W, $clog2(NR_ENTRIES), derived index width; not overridable.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- flush_bp_i  in  1  single-cycle pulse; starts a full table clear.
- debug_mode_i  in  1  when 1, resolve updates are ignored.
- lookup_valid_i  in  1  fetch lookup request this cycle.
- lookup_pc_i  in  VLEN  fetch PC to predict.
- pred_valid_o  out  1  prediction valid; one cycle after the request.
- pred_taken_o  out  1  predicted direction.
- resolve_valid_i  in  1  resolved branch from the branch unit.
- resolve_pc_i  in  VLEN  PC of the resolved instruction.
- resolve_is_branch_i  in  1  cf_type is a conditional branch (not jump/JALR/return).
- resolve_taken_i  in  1  actual direction.
- resolve_mispredict_i  in  1  frontend mispredicted this branch.
- ready_o  out  1  1 when the table is usable; 0 while clearing.

Behaviour:
- Index is resolve_pc_i[IDX_W:1] and lookup_pc_i[IDX_W:1]. Bit 0 is ignored for 16-bit alignment.
- Each row holds valid (1b) and ctr (2b).
- Reset (async, rst_i=1):
  - All rows: valid=0, ctr=2'b01.
  - State=IDLE, clear index=0.
  - pred_valid_o=0, pred_taken_o=0, ready_o=1 (combinational from state).
- State machine:
  - IDLE: flush_bp_i=1 -> CLEAR with clear index=0.
  - CLEAR: each cycle writes row[idx] to valid=0, ctr=01, then idx++.
  - CLEAR: on the write of row NR_ENTRIES-1, go to IDLE. CLEAR lasts exactly NR_ENTRIES cycles.
  - CLEAR: flush_bp_i=1 restarts idx at 0.
  - ready_o = (state==IDLE).
- Lookup (1-cycle latency):
  - pred_valid_o registers (lookup_valid_i && state==IDLE && row.valid).
  - pred_taken_o registers row.ctr[1] when the request is accepted; otherwise it is 0.
  - An invalid row gives pred_valid_o=0, pred_taken_o=0.
- Update, accepted when resolve_valid_i && resolve_is_branch_i && !debug_mode_i && state==IDLE:
  - Row invalid: valid=1; ctr=2'b10 if taken, else 2'b01.
  - Row valid and taken: ctr = (ctr==3) ? 3 : ctr+1.
  - Row valid and not taken: ctr = (ctr==0) ? 0 : ctr-1.
  - resolve_mispredict_i does not change the update rule; it only feeds the optional counter.
  - Updates arriving during CLEAR or in debug mode are dropped, not queued.
- Simultaneous events:
  - flush_bp_i and an accepted update in the same IDLE cycle: flush wins, update is dropped, CLEAR starts next cycle.
  - Lookup and update to the same index in the same cycle: lookup returns the pre-update value (read-before-write) unless the optional feature is enabled.
  - Reset asserted mid-CLEAR: immediate return to the reset state. No partial clear remains, because all rows are reset.

Optional Feature:
- Macro: BHT_UPDATE_BYPASS_EN.
- Defined: a lookup that hits the same index as an accepted update in the same cycle returns the post-update row. pred_valid_o=1 and pred_taken_o=new ctr[1].
- Not defined: read-before-write as specified above, with no forwarding mux.

Test Plan:
- Reset, then lookup pc=0x80000000 -> next cycle pred_valid_o=0, pred_taken_o=0, ready_o=1.
- Update pc=0x80000010 taken three times, then lookup 0x80000010 -> pred_valid_o=1, pred_taken_o=1, ctr=3. Three not-taken updates then a lookup -> pred_taken_o=0, ctr=0. A fourth not-taken update keeps ctr=0 (saturation).
- Train index 8 to taken, pulse flush_bp_i -> ready_o=0 for exactly 64 cycles. Updates during this window are ignored. A lookup at 0x80000010 afterwards gives pred_valid_o=0.
- debug_mode_i=1 with a taken update at 0x80000020 -> a later lookup gives pred_valid_o=0. A resolve with resolve_is_branch_i=0 also leaves the row invalid.
- Same-cycle taken update and lookup at 0x80000030 (row invalid) -> pred_valid_o=0 without the macro, pred_valid_o=1/pred_taken_o=1 with BHT_UPDATE_BYPASS_EN.
- Pulse flush_bp_i, raise rst_i at clear idx 20, release it -> ready_o=1 immediately and all rows invalid. A second flush_bp_i at idx 30 restarts the clear: 64 more cycles until ready_o=1.

Source files
------------

// File: rtl/bht_resolve_updater.sv
// bht_resolve_updater: 2-bit saturating-counter BHT trained by resolved branches, with flush-driven clear sequencer.
// Optional same-cycle update-to-lookup forwarding when BHT_UPDATE_BYPASS_EN is defined.
module bht_resolve_updater #(
  parameter int unsigned NR_ENTRIES = 64,
  parameter int unsigned VLEN       = 64
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_bp_i,
  input  logic            debug_mode_i,
  input  logic            lookup_valid_i,
  input  logic [VLEN-1:0] lookup_pc_i,
  output logic            pred_valid_o,
  output logic            pred_taken_o,
  input  logic            resolve_valid_i,
  input  logic [VLEN-1:0] resolve_pc_i,
  input  logic            resolve_is_branch_i,
  input  logic            resolve_taken_i,
  input  logic            resolve_mispredict_i,
  output logic            ready_o
);
  localparam int unsigned IDX_W = $clog2(NR_ENTRIES);
  typedef enum logic {IDLE, CLEAR} state_e;
  state_e           state_q, state_d;
  logic [IDX_W-1:0] clr_idx_q, clr_idx_d;
  logic             valid_q [NR_ENTRIES];
  logic [1:0]       ctr_q [NR_ENTRIES];
  logic [IDX_W-1:0] ridx, lidx;
  logic             upd, hit, pv_d, pt_d, pred_valid_q, pred_taken_q;
  logic [1:0]       cur_ctr, new_ctr;
  logic             unused_bits;
  assign unused_bits = ^{lookup_pc_i[VLEN-1:IDX_W+1], lookup_pc_i[0],
                         resolve_pc_i[VLEN-1:IDX_W+1], resolve_pc_i[0], resolve_mispredict_i};
  assign ridx    = resolve_pc_i[IDX_W:1];
  assign lidx    = lookup_pc_i[IDX_W:1];
  assign ready_o = (state_q == IDLE);
  // a flush in the same cycle wins over the update
  assign upd     = resolve_valid_i && resolve_is_branch_i && !debug_mode_i && ready_o && !flush_bp_i;
  assign hit     = lookup_valid_i && ready_o;
  assign cur_ctr = ctr_q[ridx];
  assign new_ctr = !valid_q[ridx] ? {resolve_taken_i, !resolve_taken_i} :
                   resolve_taken_i ? ((cur_ctr == 2'b11) ? 2'b11 : cur_ctr + 2'b01) :
                                     ((cur_ctr == 2'b00) ? 2'b00 : cur_ctr - 2'b01);
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    if (flush_bp_i) begin
      state_d   = CLEAR;
      clr_idx_d = '0;
    end else if (state_q == CLEAR) begin
      clr_idx_d = clr_idx_q + 1'b1;
      state_d   = (&clr_idx_q) ? IDLE : CLEAR;
    end
  end
`ifdef BHT_UPDATE_BYPASS_EN
  logic fwd;
  assign fwd  = upd && (lidx == ridx);
  assign pv_d = hit && (fwd || valid_q[lidx]);
  assign pt_d = hit && (fwd ? new_ctr[1] : valid_q[lidx] && ctr_q[lidx][1]);
`else
  assign pv_d = hit && valid_q[lidx];
  assign pt_d = pv_d && ctr_q[lidx][1];
`endif
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      clr_idx_q    <= '0;
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_idx_q    <= clr_idx_d;
      pred_valid_q <= pv_d;
      pred_taken_q <= pt_d;
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NR_ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b01;
      end
    end else if (state_q == CLEAR) begin
      valid_q[clr_idx_q] <= 1'b0;
      ctr_q[clr_idx_q]   <= 2'b01;
    end else if (upd) begin
      valid_q[ridx] <= 1'b1;
      ctr_q[ridx]   <= new_ctr;
    end
  end
  assign pred_valid_o = pred_valid_q;
  assign pred_taken_o = pred_taken_q;
endmodule

// File: tb/tb_bht_resolve_updater.sv
// tb_bht_resolve_updater: directed scoreboard bench; lookups queue expected {valid,taken}, a monitor checks responses.
module tb_bht_resolve_updater;
  logic        clk = 1'b0, rst_i = 1'b1, flush = 1'b0, dbg = 1'b0;
  logic        lv = 1'b0, rv = 1'b0, rb = 1'b0, rt = 1'b0, rm = 1'b0;
  logic [63:0] lpc = '0, rpc = '0;
  logic        pred_valid, pred_taken, ready;
  int          total = 0, bad = 0, n;
  logic [1:0]  exp_q [$];
  logic        pend = 1'b0;
`ifdef BHT_UPDATE_BYPASS_EN
  localparam logic [1:0] BYP = 2'b11;
`else
  localparam logic [1:0] BYP = 2'b00;
`endif
  bht_resolve_updater dut (
    .clk_i(clk), .rst_i(rst_i), .flush_bp_i(flush), .debug_mode_i(dbg),
    .lookup_valid_i(lv), .lookup_pc_i(lpc), .pred_valid_o(pred_valid), .pred_taken_o(pred_taken),
    .resolve_valid_i(rv), .resolve_pc_i(rpc), .resolve_is_branch_i(rb), .resolve_taken_i(rt),
    .resolve_mispredict_i(rm), .ready_o(ready)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [1:0] got, input logic [1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%b want=%b t=%0t", name, got, want, $time);
    end
  endtask
  always @(posedge clk) pend <= lv;
  always @(negedge clk) begin
    if (pend) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL pred: response with empty scoreboard t=%0t", $time);
      end else chk("pred", {pred_valid, pred_taken}, exp_q.pop_front());
    end else if (pred_valid) begin
      total++;
      bad++;
      $display("FAIL pred: spurious pred_valid=1 want=0 t=%0t", $time);
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic resolve(input logic [63:0] pc, input logic tk, input logic br = 1'b1);
    rv = 1'b1; rpc = pc; rt = tk; rb = br; rm = ~tk;
    tick;
    rv = 1'b0; rb = 1'b0; rm = 1'b0;
  endtask
  task automatic lookup(input logic [63:0] pc, input logic [1:0] e);
    lv = 1'b1; lpc = pc; exp_q.push_back(e);
    tick;
    lv = 1'b0;
  endtask
  task automatic wait_ready(output int cnt);
    cnt = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (ready) break;
      cnt++;
    end
    tick;
  endtask
  initial begin
    #2;
    chk("reset_ready", {1'b0, ready}, 2'b01);
    chk("reset_pred", {pred_valid, pred_taken}, 2'b00);
    #10 rst_i = 1'b0;
    tick;
    lookup(64'h8000_0000, 2'b00);
    chk("ready_idle", {1'b0, ready}, 2'b01);
    repeat (3) resolve(64'h8000_0010, 1'b1);
    lookup(64'h8000_0010, 2'b11);
    resolve(64'h8000_0010, 1'b0);
    lookup(64'h8000_0010, 2'b11);
    resolve(64'h8000_0010, 1'b0);
    lookup(64'h8000_0010, 2'b10);
    resolve(64'h8000_0010, 1'b0);
    lookup(64'h8000_0010, 2'b10);
    resolve(64'h8000_0010, 1'b0);
    resolve(64'h8000_0010, 1'b1);
    lookup(64'h8000_0010, 2'b10);
    resolve(64'h8000_0010, 1'b1);
    lookup(64'h8000_0010, 2'b11);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    n = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (ready) break;
      n++;
      if (n == 10) begin rv = 1'b1; rb = 1'b1; rt = 1'b1; rpc = 64'h8000_0040; end
      if (n == 11) begin rv = 1'b0; rb = 1'b0; end
      if (n == 20) begin lv = 1'b1; lpc = 64'h8000_0010; exp_q.push_back(2'b00); end
      if (n == 21) lv = 1'b0;
    end
    tick;
    chk("clear_len_hi", {1'b0, n == 64}, 2'b01);
    lookup(64'h8000_0010, 2'b00);
    lookup(64'h8000_0040, 2'b00);
    dbg = 1'b1;
    resolve(64'h8000_0020, 1'b1);
    dbg = 1'b0;
    lookup(64'h8000_0020, 2'b00);
    resolve(64'h8000_0020, 1'b1, 1'b0);
    lookup(64'h8000_0020, 2'b00);
    resolve(64'h8000_0020, 1'b1);
    lookup(64'h8000_0020, 2'b11);
    rv = 1'b1; rb = 1'b1; rt = 1'b1; rpc = 64'h8000_0030;
    lv = 1'b1; lpc = 64'h8000_0030; exp_q.push_back(BYP);
    tick;
    rv = 1'b0; rb = 1'b0; lv = 1'b0;
    lookup(64'h8000_0030, 2'b11);
    rv = 1'b1; rb = 1'b1; rt = 1'b1; rpc = 64'h8000_0050; flush = 1'b1;
    tick;
    rv = 1'b0; rb = 1'b0; flush = 1'b0;
    wait_ready(n);
    chk("clear_len_flush_upd", {1'b0, n == 64}, 2'b01);
    lookup(64'h8000_0050, 2'b00);
    resolve(64'h8000_0070, 1'b1);
    resolve(64'h8000_0030, 1'b1);
    lookup(64'h8000_0070, 2'b11);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    repeat (20) tick;
    chk("mid_clear_ready", {1'b0, ready}, 2'b00);
    rst_i = 1'b1;
    #1;
    chk("async_rst_ready", {1'b0, ready}, 2'b01);
    tick;
    rst_i = 1'b0;
    tick;
    chk("post_rst_ready", {1'b0, ready}, 2'b01);
    lookup(64'h8000_0070, 2'b00);
    lookup(64'h8000_0030, 2'b00);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    repeat (30) tick;
    chk("restart_pre_ready", {1'b0, ready}, 2'b00);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    wait_ready(n);
    chk("clear_len_restart", {1'b0, n == 64}, 2'b01);
    repeat (3) tick;
    chk("scoreboard_empty", {1'b0, exp_q.size() == 0}, 2'b01);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
